rr_grant_arbiter: RTL



---
 rtl/rr_grant_arbiter_if.sv | 25 ++
 rtl/rr_grant_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master: arbiter side (drives grant); slave: requester side (drives req/done).
interface rr_grant_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  grant_idx;
  logic        grant_en;
  logic        timeout;

  modport master (
    input  req,
    input  done,
    output grant_idx,
    output grant_en,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  grant_idx,
    input  grant_en,
    input  timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Sixteen-way round-robin arbiter feeding a 4-to-16 decoder (index + enable).
// Optional hold-limit revocation is built when RR_ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_grant_arbiter_if.master    bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HoldMax8 = 8'(HOLD_MAX);

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_ptr;
  logic [3:0]  w_ptr_nx;
  logic [3:0]  r_grant_idx;
  logic [3:0]  w_grant_idx_nx;
  logic        r_timeout;
  logic        w_timeout_nx;
  logic [3:0]  w_sel;
  logic        w_end_normal;
  logic        w_end_limit;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0]  r_hold_cnt;
  logic [7:0]  w_hold_cnt_nx;

  assign w_end_limit = (r_hold_cnt == HoldMax8);
`else
  // HOLD_MAX has no effect without the timeout path.
  logic        w_unused_hold;

  assign w_unused_hold = ^HoldMax8;
  assign w_end_limit   = 1'b0;
`endif

  assign w_end_normal = bus.done || !bus.req[r_grant_idx];

  // First set request at or above r_ptr, wrapping; descending scan so the
  // smallest rotated offset is the one left in w_sel.
  always_comb begin
    logic [3:0] v_pos;
    w_sel = '0;
    v_pos = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      v_pos = r_ptr + 4'(i - 1);
      if (bus.req[v_pos]) begin
        w_sel = v_pos;
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_grant_idx_nx = r_grant_idx;
    w_timeout_nx   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    w_hold_cnt_nx  = r_hold_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.req != '0) begin
          w_grant_idx_nx = w_sel;
          w_state_nx     = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          w_hold_cnt_nx  = 8'd1;
`endif
        end
      end
      GRANT: begin
        if (w_end_normal || w_end_limit) begin
          w_state_nx   = IDLE;
          w_ptr_nx     = r_grant_idx + 4'd1;
          w_timeout_nx = w_end_limit && !w_end_normal;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (r_hold_cnt < HoldMax8) begin
          w_hold_cnt_nx = r_hold_cnt + 8'd1;
        end
`endif
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_timeout   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_grant_idx <= w_grant_idx_nx;
      r_timeout   <= w_timeout_nx;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold_cnt  <= w_hold_cnt_nx;
`endif
    end
  end

  assign bus.grant_idx = r_grant_idx;
  assign bus.grant_en  = (r_state == GRANT);
  assign bus.timeout   = r_timeout;

endmodule
